// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared 7-segment glyph table and scan-decoder types
// Contents:
//   SEG7_GLYPH[0:15]  active-low segment pattern (bit6..0 = g..a) for hex digit 0..F
//   SEG7_BLANK        all segments off
//   scan_state_t      capture FSM states of the scan decoder
package seg7_pkg;

    localparam logic [6:0] SEG7_BLANK = 7'h7F;

    localparam logic [6:0] SEG7_GLYPH [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h27, 7'h21, 7'h06, 7'h0E
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_HOLD
    } scan_state_t;

endpackage

// File: rtl/seg7_pattern_decoder.sv
// rtl/seg7_pattern_decoder.sv - combinational 7-segment pattern to hex nibble decoder
// Ports:
//   pattern  in   7  active-low segment pattern, bit6..0 = g..a
//   nibble   out  4  decoded hex value (0 for blank or illegal patterns)
//   err      out  1  pattern is neither a glyph nor blank
//   blank    out  1  pattern is all segments off
import seg7_pkg::*;

module seg7_pattern_decoder (
    input  logic [6:0] pattern,
    output logic [3:0] nibble,
    output logic       err,
    output logic       blank
);

    always_comb begin
        nibble = 4'h0;
        err    = 1'b1;
        blank  = 1'b0;
        if (pattern == SEG7_BLANK) begin
            err   = 1'b0;
            blank = 1'b1;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (pattern == SEG7_GLYPH[i]) begin
                    nibble = 4'(i);
                    err    = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// rtl/seg7_scan_decoder.sv - multiplexed 7-segment display reader with frame assembly
// Ports:
//   clk            in   1             rising-edge clock
//   rst_n          in   1             asynchronous active-low reset
//   seg_n          in   7             segment bus, bit6..0 = g..a, 0 = lit
//   an_n           in   NUM_DIGITS    digit strobes, one-hot-low selects a digit
//   value_o        out  4*NUM_DIGITS  digit i nibble at [4i+3:4i]
//   digit_err_o    out  NUM_DIGITS    digit i showed an illegal pattern
//   blank_o        out  NUM_DIGITS    digit i was blank
//   frame_valid_o  out  1             one-cycle pulse when the outputs update
import seg7_pkg::*;

module seg7_scan_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg_n,
    input  logic [NUM_DIGITS-1:0]   an_n,
    output logic [4*NUM_DIGITS-1:0] value_o,
    output logic [NUM_DIGITS-1:0]   digit_err_o,
    output logic [NUM_DIGITS-1:0]   blank_o,
    output logic                    frame_valid_o
);

    localparam int BW = NUM_DIGITS + 7;
    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [BW-1:0] sync_q1, sync_q2, prev_q;
    logic [CW-1:0] stable_cnt;
    scan_state_t   state, state_next;

    logic [NUM_DIGITS-1:0]   an_s;
    logic [6:0]              seg_s;
    logic                    changed, settled, one_hot, capture, publish;
    logic [IW-1:0]           digit_idx;
    logic [3:0]              zero_cnt;
    logic [3:0]              dec_nibble;
    logic                    dec_err, dec_blank;
    logic [NUM_DIGITS-1:0]   seen, seen_next;
    logic [4*NUM_DIGITS-1:0] shadow_value;
    logic [NUM_DIGITS-1:0]   shadow_err, shadow_blank;

    assign an_s    = sync_q2[BW-1:7];
    assign seg_s   = sync_q2[6:0];
    assign changed = (sync_q2 != prev_q);
    // The capture fires in the cycle whose count update would reach SETTLE_CYCLES.
    assign settled = !changed && (stable_cnt >= CW'(SETTLE_CYCLES - 1));
    assign publish = &seen;

    always_comb begin
        zero_cnt  = 4'd0;
        digit_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!an_s[i]) begin
                zero_cnt  = zero_cnt + 4'd1;
                digit_idx = IW'(i);
            end
        end
        one_hot = (zero_cnt == 4'd1);
    end

    seg7_pattern_decoder u_decoder (
        .pattern (seg_s),
        .nibble  (dec_nibble),
        .err     (dec_err),
        .blank   (dec_blank)
    );

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (one_hot) state_next = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (!one_hot) begin
                    state_next = ST_IDLE;
                end else if (settled) begin
                    capture    = 1'b1;
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (changed) state_next = one_hot ? ST_SETTLE : ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // A digit seen twice before the frame completes starts a new frame from that digit.
    always_comb begin
        seen_next = seen;
        if (publish) begin
            seen_next = '0;
        end else if (capture) begin
            if (seen[digit_idx]) seen_next = '0;
            seen_next[digit_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1       <= '0;
            sync_q2       <= '0;
            prev_q        <= '0;
            stable_cnt    <= '0;
            state         <= ST_IDLE;
            seen          <= '0;
            shadow_value  <= '0;
            shadow_err    <= '0;
            shadow_blank  <= '0;
            value_o       <= '0;
            digit_err_o   <= '0;
            blank_o       <= '0;
            frame_valid_o <= 1'b0;
        end else begin
            sync_q1 <= {an_n, seg_n};
            sync_q2 <= sync_q1;
            prev_q  <= sync_q2;
            if (changed) begin
                stable_cnt <= '0;
            end else if (stable_cnt != CW'(SETTLE_CYCLES)) begin
                stable_cnt <= stable_cnt + 1'b1;
            end
            state <= state_next;
            seen  <= seen_next;
            if (capture) begin
                shadow_value[{digit_idx, 2'b00} +: 4] <= dec_nibble;
                shadow_err[digit_idx]                 <= dec_err;
                shadow_blank[digit_idx]               <= dec_blank;
            end
            frame_valid_o <= publish;
            if (publish) begin
                value_o     <= shadow_value;
                digit_err_o <= shadow_err;
                blank_o     <= shadow_blank;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb/tb_seg7_scan_decoder.sv - self-checking bench for seg7_scan_decoder
module tb_seg7_scan_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  seg_n;
    logic [3:0]  an_n;
    logic [15:0] value_o;
    logic [3:0]  digit_err_o;
    logic [3:0]  blank_o;
    logic        frame_valid_o;

    seg7_scan_decoder #(.NUM_DIGITS(4), .SETTLE_CYCLES(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .seg_n         (seg_n),
        .an_n          (an_n),
        .value_o       (value_o),
        .digit_err_o   (digit_err_o),
        .blank_o       (blank_o),
        .frame_valid_o (frame_valid_o)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int pulses   = 0;

    always @(negedge clk) if (frame_valid_o === 1'b1) pulses++;

    // Reference model: digit-level frame assembly
    logic [6:0]  glyph_tab [16];
    logic [3:0]  sh_val   [4];
    logic        sh_err   [4];
    logic        sh_blank [4];
    logic        m_seen   [4];
    logic [15:0] exp_value;
    logic [3:0]  exp_err, exp_blank;
    int          exp_pulses;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_decode(input logic [6:0] p, output logic [3:0] n,
                                output logic e, output logic b);
        n = 4'h0; e = 1'b1; b = 1'b0;
        if (p == 7'h7F) begin
            e = 1'b0; b = 1'b1;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (glyph_tab[i] == p) begin
                    n = i[3:0]; e = 1'b0;
                end
            end
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            sh_val[i] = 4'h0; sh_err[i] = 1'b0; sh_blank[i] = 1'b0; m_seen[i] = 1'b0;
        end
        exp_value = 16'h0; exp_err = 4'h0; exp_blank = 4'h0;
    endtask

    task automatic model_capture(input int d, input logic [6:0] p);
        bit all_seen;
        if (m_seen[d]) for (int i = 0; i < 4; i++) m_seen[i] = 1'b0;
        m_seen[d] = 1'b1;
        model_decode(p, sh_val[d], sh_err[d], sh_blank[d]);
        all_seen = 1'b1;
        for (int i = 0; i < 4; i++) if (!m_seen[i]) all_seen = 1'b0;
        if (all_seen) begin
            for (int i = 0; i < 4; i++) begin
                exp_value[4*i +: 4] = sh_val[i];
                exp_err[i]          = sh_err[i];
                exp_blank[i]        = sh_blank[i];
                m_seen[i]           = 1'b0;
            end
            exp_pulses++;
        end
    endtask

    function automatic int lit_digit(input logic [3:0] an);
        int cnt = 0;
        int idx = -1;
        for (int i = 0; i < 4; i++) if (!an[i]) begin cnt++; idx = i; end
        return (cnt == 1) ? idx : -1;
    endfunction

    // Drive one strobe for `hold` clocks followed by 2 blanking clocks, then compare.
    // Holds are either <=3 (too short to capture) or >=8 (always captured).
    task automatic scan(input logic [3:0] an, input logic [6:0] seg, input int hold);
        int d;
        an_n = an; seg_n = seg;
        repeat (hold) @(negedge clk);
        an_n = 4'hF; seg_n = 7'($urandom);
        repeat (2) @(negedge clk);
        d = lit_digit(an);
        if (d >= 0 && hold >= 8) model_capture(d, seg);
        check("pulse_count", pulses, exp_pulses);
        check("value_o", value_o, exp_value);
        check("digit_err_o", digit_err_o, exp_err);
        check("blank_o", blank_o, exp_blank);
    endtask

    function automatic logic [6:0] rand_pattern();
        int sel = $urandom_range(0, 9);
        if (sel < 6) return glyph_tab[$urandom_range(0, 15)];
        if (sel == 6) return 7'h7F;
        return 7'($urandom);
    endfunction

    initial begin
        logic [3:0] an;
        glyph_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                      7'h00, 7'h10, 7'h08, 7'h03, 7'h27, 7'h21, 7'h06, 7'h0E};
        exp_pulses = 0;
        model_reset();

        // 1: reset with random inputs
        rst_n = 1'b0; an_n = 4'($urandom); seg_n = 7'($urandom);
        repeat (5) begin
            @(negedge clk);
            an_n = 4'($urandom); seg_n = 7'($urandom);
        end
        check("rst_value", value_o, 16'h0);
        check("rst_err", digit_err_o, 4'h0);
        check("rst_blank", blank_o, 4'h0);
        check("rst_pulse", pulses, 0);
        an_n = 4'hF; seg_n = 7'h7F;
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 2: basic frame A51F
        scan(4'b1110, 7'h0E, 8);
        scan(4'b1101, 7'h79, 8);
        scan(4'b1011, 7'h12, 8);
        scan(4'b0111, 7'h08, 8);
        check("frame_a51f", value_o, 16'hA51F);
        check("frame_a51f_pulse", pulses, 1);

        // 3: too-short digit 0 is not captured, so no frame until it is
        scan(4'b1110, 7'h40, 3);
        scan(4'b1101, 7'h24, 8);
        scan(4'b1011, 7'h30, 8);
        scan(4'b0111, 7'h19, 8);
        check("short_no_pulse", pulses, 1);
        scan(4'b1110, 7'h40, 8);

        // 4: illegal and blank patterns
        scan(4'b1110, 7'h02, 8);
        scan(4'b1101, 7'h7E, 8);
        scan(4'b1011, 7'h7F, 8);
        scan(4'b0111, 7'h21, 8);
        check("err_pattern", digit_err_o, 4'b0010);
        check("blank_pattern", blank_o, 4'b0100);
        check("err_blank_nibbles", value_o[11:4], 8'h00);

        // 5: repeated digits restart the frame
        scan(4'b1110, 7'h78, 8);
        scan(4'b1101, 7'h00, 8);
        scan(4'b1110, 7'h10, 8);
        scan(4'b1101, 7'h08, 8);
        scan(4'b1011, 7'h03, 8);
        scan(4'b0111, 7'h27, 8);
        check("restart_value", value_o, 16'hCBA9);

        // randomized scans, including multi-hot strobes and short holds
        repeat (40) begin
            if ($urandom_range(0, 9) < 8) begin
                an = 4'hF;
                an[$urandom_range(0, 3)] = 1'b0;
            end else begin
                an = 4'($urandom);
            end
            scan(an, rand_pattern(), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3)
                                                                 : $urandom_range(8, 12));
        end

        // 6: reset in the middle of a frame
        scan(4'b1110, 7'h19, 8);
        scan(4'b1101, 7'h12, 8);
        scan(4'b1011, 7'h02, 8);
        scan(4'b0111, 7'h78, 8);
        scan(4'b1110, 7'h06, 8);
        scan(4'b1101, 7'h0E, 8);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("midrst_value", value_o, 16'h0);
        check("midrst_err", digit_err_o, 4'h0);
        check("midrst_blank", blank_o, 4'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        scan(4'b1011, 7'h24, 8);
        scan(4'b0111, 7'h30, 8);
        scan(4'b1110, 7'h79, 8);
        scan(4'b1101, 7'h40, 8);
        check("post_rst_value", value_o, 16'h3201);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
